// File: rtl/hazard_pipe_regs_if.sv
// Hazard-control link between the hazard unit (master) and the pipeline
// registers (slave): stall/flush requests and the decode-stage branch redirect.
interface hazard_pipe_regs_if;
   logic        StallF;
   logic        StallD;
   logic        FlushE;
   logic        PCSrcD;
   logic [31:0] PCBranchD;

   modport master (output StallF, StallD, FlushE, PCSrcD, PCBranchD);
   modport slave  (input  StallF, StallD, FlushE, PCSrcD, PCBranchD);
endinterface

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core under hazard control.
// Optional performance counters are built when HAZARD_PIPE_PERF_CNT_EN is defined.
module hazard_pipe_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   hazard_pipe_regs_if.slave         hz,
   input  logic [31:0]               InstrF,
   input  logic                      RegWriteD,
   input  logic                      MemToRegD,
   input  logic                      MemWriteD,
   input  logic                      ALUSrcD,
   input  logic                      RegDstD,
   input  logic [2:0]                ALUControlD,
   input  logic [31:0]               RD1D,
   input  logic [31:0]               RD2D,
   input  logic [31:0]               SignImmD,
   input  logic [4:0]                RsD,
   input  logic [4:0]                RtD,
   input  logic [4:0]                RdD,
   output logic [31:0]               PCF,
   output logic [31:0]               InstrD,
   output logic [31:0]               PCPlus4D,
   output logic                      ValidD,
   output logic                      ValidE,
   output logic                      RegWriteE,
   output logic                      MemToRegE,
   output logic                      MemWriteE,
   output logic                      ALUSrcE,
   output logic                      RegDstE,
   output logic [2:0]                ALUControlE,
   output logic [31:0]               RD1E,
   output logic [31:0]               RD2E,
   output logic [31:0]               SignImmE,
   output logic [4:0]                RsE,
   output logic [4:0]                RtE,
   output logic [4:0]                RdE,
   output logic [31:0]               StallCnt,
   output logic [31:0]               FlushCnt
);

   logic        redirect_pend;
   logic [31:0] pc_plus4;
   logic        squash_d;

   assign pc_plus4 = PCF + 32'd4;
   // A redirect that arrived while IF/ID was stalled still kills the next fetch.
   assign squash_d = !hz.StallD && (hz.PCSrcD || redirect_pend);

   // NOTE: reset is synchronous, so it sits inside the clocked block as the
   // first branch; all state uses non-blocking assignment to avoid races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PCF <= RESET_PC;
      end else if (hz.StallF) begin
         PCF <= PCF;
      end else if (hz.PCSrcD) begin
         PCF <= hz.PCBranchD;
      end else begin
         PCF <= pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         InstrD        <= '0;
         PCPlus4D      <= '0;
         ValidD        <= 1'b0;
         redirect_pend <= 1'b0;
      end else if (hz.StallD) begin
         if (hz.PCSrcD) redirect_pend <= 1'b1;
      end else if (squash_d) begin
         InstrD        <= '0;
         PCPlus4D      <= '0;
         ValidD        <= 1'b0;
         redirect_pend <= 1'b0;
      end else begin
         InstrD        <= InstrF;
         PCPlus4D      <= pc_plus4;
         ValidD        <= 1'b1;
      end
   end

   // Flush clears data too, so a bubble is indistinguishable from reset.
   always_ff @(posedge clk) begin
      if (!rst_n || hz.FlushE) begin
         ValidE      <= 1'b0;
         RegWriteE   <= 1'b0;
         MemToRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         RegDstE     <= 1'b0;
         ALUControlE <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         SignImmE    <= '0;
         RsE         <= '0;
         RtE         <= '0;
         RdE         <= '0;
      end else begin
         ValidE      <= ValidD;
         RegWriteE   <= RegWriteD;
         MemToRegE   <= MemToRegD;
         MemWriteE   <= MemWriteD;
         ALUSrcE     <= ALUSrcD;
         RegDstE     <= RegDstD;
         ALUControlE <= ALUControlD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         SignImmE    <= SignImmD;
         RsE         <= RsD;
         RtE         <= RtD;
         RdE         <= RdD;
      end
   end

`ifdef HAZARD_PIPE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (hz.StallD)              StallCnt <= StallCnt + 32'd1;
         if (hz.FlushE || squash_d)  FlushCnt <= FlushCnt + 32'd1;
      end
   end
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Self-checking bench for hazard_pipe_regs: directed scenarios followed by
// randomized stall/flush/branch traffic against a stage-content reference model.
module tb_hazard_pipe_regs;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_pipe_regs_if hif ();

   logic [31:0] InstrF, RD1D, RD2D, SignImmD;
   logic        RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD;
   logic [2:0]  ALUControlD;
   logic [4:0]  RsD, RtD, RdD;
   logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE, StallCnt, FlushCnt;
   logic        ValidD, ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [2:0]  ALUControlE;
   logic [4:0]  RsE, RtE, RdE;

   hazard_pipe_regs #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .hz(hif.slave), .InstrF(InstrF),
      .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
      .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD), .ValidE(ValidE),
      .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
      .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   // Contents of the E stage as the reference model sees it.
   typedef struct {
      logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst;
      logic [2:0]  aluctl;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
   } e_stage_t;

   // Fetched instruction sitting in decode.
   typedef struct {
      logic [31:0] instr, pcp4;
      logic        valid;
   } d_stage_t;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc;
   d_stage_t    m_d;
   e_stage_t    m_e;
   logic        m_pend;
   logic [31:0] m_sc, m_fc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = RESET_PC;
      m_d    = '{instr: 32'd0, pcp4: 32'd0, valid: 1'b0};
      m_e    = '{default: '0};
      m_pend = 1'b0;
      m_sc   = 32'd0;
      m_fc   = 32'd0;
   endtask

   // Advance every stage by one clock using the inputs that were present at the edge.
   task automatic model_edge();
      logic squash;
      if (!rst_n) begin
         model_reset();
         return;
      end
      squash = !hif.StallD && (hif.PCSrcD || m_pend);
      if (hif.StallD) m_sc = m_sc + 32'd1;
      if (hif.FlushE || squash) m_fc = m_fc + 32'd1;

      if (hif.FlushE) m_e = '{default: '0};
      else m_e = '{valid: m_d.valid, regwrite: RegWriteD, memtoreg: MemToRegD,
                   memwrite: MemWriteD, alusrc: ALUSrcD, regdst: RegDstD,
                   aluctl: ALUControlD, rd1: RD1D, rd2: RD2D, imm: SignImmD,
                   rs: RsD, rt: RtD, rd: RdD};

      if (hif.StallD) begin
         if (hif.PCSrcD) m_pend = 1'b1;
      end else if (squash) begin
         m_d    = '{instr: 32'd0, pcp4: 32'd0, valid: 1'b0};
         m_pend = 1'b0;
      end else begin
         m_d = '{instr: InstrF, pcp4: m_pc + 32'd4, valid: 1'b1};
      end

      if (!hif.StallF) m_pc = hif.PCSrcD ? hif.PCBranchD : m_pc + 32'd4;
   endtask

   task automatic check_all();
      logic [31:0] exp_sc, exp_fc;
`ifdef HAZARD_PIPE_PERF_CNT_EN
      exp_sc = m_sc;
      exp_fc = m_fc;
`else
      exp_sc = 32'd0;
      exp_fc = 32'd0;
`endif
      check("PCF", PCF, m_pc);
      check("InstrD", InstrD, m_d.instr);
      check("PCPlus4D", PCPlus4D, m_d.pcp4);
      check("ValidD", {31'd0, ValidD}, {31'd0, m_d.valid});
      check("ValidE", {31'd0, ValidE}, {31'd0, m_e.valid});
      check("ctrlE", {26'd0, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ValidE},
            {26'd0, m_e.regwrite, m_e.memtoreg, m_e.memwrite, m_e.alusrc, m_e.regdst, m_e.valid});
      check("ALUControlE", {29'd0, ALUControlE}, {29'd0, m_e.aluctl});
      check("RD1E", RD1E, m_e.rd1);
      check("RD2E", RD2E, m_e.rd2);
      check("SignImmE", SignImmE, m_e.imm);
      check("regsE", {17'd0, RsE, RtE, RdE}, {17'd0, m_e.rs, m_e.rt, m_e.rd});
      check("StallCnt", StallCnt, exp_sc);
      check("FlushCnt", FlushCnt, exp_fc);
   endtask

   // One clock: model follows the edge, then outputs are compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_hz(input logic sf, input logic sd, input logic fe,
                         input logic br, input logic [31:0] tgt);
      hif.StallF = sf; hif.StallD = sd; hif.FlushE = fe;
      hif.PCSrcD = br; hif.PCBranchD = tgt;
   endtask

   task automatic randomize_decode();
      InstrF      = $urandom;
      RegWriteD   = 1'($urandom); MemToRegD = 1'($urandom); MemWriteD = 1'($urandom);
      ALUSrcD     = 1'($urandom); RegDstD   = 1'($urandom);
      ALUControlD = 3'($urandom);
      RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
      RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      randomize_decode();

      // Reset then run free.
      InstrF = 32'h014B4820;
      step(); step();
      check("reset_PCF", PCF, RESET_PC);
      check("reset_ValidD", {31'd0, ValidD}, 32'd0);
      rst_n = 1'b1;
      step();
      check("run_PCF", PCF, 32'd4);
      check("run_InstrD", InstrD, 32'h014B4820);
      check("run_PCPlus4D", PCPlus4D, 32'd4);
      check("run_ValidD", {31'd0, ValidD}, 32'd1);
      InstrF = 32'h012A6020;
      step();
      check("run_ValidE", {31'd0, ValidE}, 32'd1);

      // Load-use: stall fetch/decode, bubble execute.
      RsD = 5'd9; RtD = 5'd10; RegWriteD = 1'b1; MemToRegD = 1'b1;
      set_hz(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      step();
      check("lu_PCF", PCF, 32'd8);
      check("lu_InstrD", InstrD, 32'h012A6020);
      check("lu_bubble", {27'd0, RegWriteE, MemToRegE, RsE}, 32'd0);
      check("lu_ValidE", {31'd0, ValidE}, 32'd0);
      set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      check("lu_RsE", {27'd0, RsE}, 32'd9);
      check("lu_RtE", {27'd0, RtE}, 32'd10);

      // Branch taken in decode.
      set_hz(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
      step();
      check("br_PCF", PCF, 32'h40);
      check("br_InstrD", InstrD, 32'd0);
      check("br_ValidD", {31'd0, ValidD}, 32'd0);

      // Branch while decode is stalled: held, then squashed.
      set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      InstrF = 32'h8C0A0004;
      step();
      set_hz(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
      step();
      check("bs_held", InstrD, 32'h8C0A0004);
      set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      check("bs_squash", InstrD, 32'd0);
      check("bs_ValidD", {31'd0, ValidD}, 32'd0);

      // PC wrap, then reset in the middle of a stall.
      set_hz(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      step();
      set_hz(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      check("wrap_pre", PCF, 32'hFFFF_FFFC);
      step();
      check("wrap_PCF", PCF, 32'd0);
      set_hz(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
      step();
      rst_n = 1'b0;
      step();
      check("mr_PCF", PCF, RESET_PC);
      check("mr_D", {InstrD | PCPlus4D}, 32'd0);
      check("mr_valid", {30'd0, ValidD, ValidE}, 32'd0);
      check("mr_cnt", StallCnt | FlushCnt, 32'd0);

      // Counter scenario: 3 decode stalls and 2 taken branches.
      rst_n = 1'b1;
      set_hz(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      step(); step(); step();
      set_hz(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
      step(); step();
`ifdef HAZARD_PIPE_PERF_CNT_EN
      check("perf_StallCnt", StallCnt, 32'd3);
      check("perf_FlushCnt", FlushCnt, 32'd2);
`else
      check("perf_StallCnt", StallCnt, 32'd0);
      check("perf_FlushCnt", FlushCnt, 32'd0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         set_hz(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                {$urandom, 2'b00} | 32'h0);
         if ($urandom_range(0, 7) == 0) hif.PCBranchD = 32'hFFFF_FFFC;
         randomize_decode();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
